sc_sng_stream: RTL and testbench
================================

# sc_sng_stream

Parametrised stochastic-number stream generator for the stochastic-computing datapath. It produces one bitstream run per start request. An LFSR feeds a scrambled comparator to generate a stochastic bit x0. A DEPTH-stage delay chain produces decorrelated copies of x0, and a mode-selectable gate combines them. The block counts the ones in a fixed-length run and reports the count with a done pulse; it replaces the fixed 8-bit, 4-input OR-only generator.

## Interface
- WIDTH, 8, LFSR/comparator width
- TAPS, 8'b0010_1101, feedback mask; new MSB = XOR of state bits set in TAPS (default polynomial 0x12D, maximal)
- INV_MASK, 8'b1101_0100, comparator operand inversion mask
- DEPTH, 4, number of combined taps x0..x(DEPTH-1), ≥2
- LEN, 255, cycles per run
- CNT_W, $clog2(LEN+1), ones-count width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin run; sampled in IDLE or DONE only
- seed  in  WIDTH  LFSR seed, latched on accepted start
- prob  in  WIDTH  target probability (binary), latched on accepted start
- mode  in  2  combine mode, latched on accepted start: 0 OR, 1 AND, 2 XOR, 3 pass x0
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run
- bit_out  out  1  registered combined bit
- ones_count  out  CNT_W  ones in last run, held until next accepted start
- lfsr_q  out  WIDTH  current LFSR state (debug/chaining)

## Operation
- FSM: IDLE -> RUN on start; RUN -> DONE after LEN cycles; DONE -> IDLE, or DONE -> RUN if start is high.
- Accepted start:
  - lfsr <= seed, or 1 if seed==0 (lock-up guard)
  - delay chain <= 0, ones_count <= 0, cycle counter <= 0
  - prob/mode latched
- RUN cycle k (k=0..LEN-1):
  - cmp = bitreverse(lfsr) ^ INV_MASK
  - x0 = (cmp < prob_q), unsigned
  - x[i] = x0 from cycle k-i, for i = 1..DEPTH-1
  - c = OR/AND/XOR of x[0..DEPTH-1], or x0 in mode 3
  - bit_out <= c; ones_count += c; delay chain shifts; lfsr shifts right with the new MSB = ^(lfsr & TAPS)
- Outside RUN: lfsr, delay chain and ones_count hold; bit_out <= 0.
- start while busy is ignored; prob/mode changes mid-run have no effect.
- ones_count cannot overflow (CNT_W ≥ bits of LEN).

## Timing
- Reset values: state IDLE, busy 0, done 0, bit_out 0, ones_count 0, lfsr_q 1, delay chain 0.
- Start accepted at edge t: busy=1 from t+1 for exactly LEN cycles; done=1 at cycle t+LEN+1 with busy=0.
- ones_count is final in the same cycle done is high.
- bit_out lags c by one cycle; the final bit_out of a run appears alongside done.
- Back-to-back: start high during done begins the next run at that edge. busy rises the next cycle with no IDLE gap.
- rst_n low mid-run: next edge forces the reset values above; no done pulse; the aborted count is discarded.
- prob=0: x0 is never 1. prob=2^WIDTH-1: x0 is 0 only when cmp is all ones.

## Structure
- Package sc_pkg:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_OR=0, MODE_AND=1, MODE_XOR=2, MODE_PASS=3
  - default TAPS/INV_MASK constants
- Sub-module sc_lfsr (WIDTH, TAPS): load/seed, enable, state output; reused by other SNGs.
- Top: FSM, cycle counter, comparator, delay chain, combiner, ones counter.

## Test plan
- Default params, seed=0x01, sample lfsr_q over a free run -> period exactly 255; every nonzero state seen once.
- prob=0x00, mode OR, start -> done at t+256; ones_count=0; bit_out never 1.
- prob=0xFF, mode PASS, seed=0x5A -> ones_count=254. mode OR -> ones_count 254 or 255, matching the bit-accurate model. mode AND -> value in [248,252], matching the model.
- seed=0x00, prob=0x80, mode XOR -> identical to a run with seed=0x01; count matches the model.
- rst_n pulled low at RUN cycle 100 -> next cycle: busy 0, ones_count 0, bit_out 0, lfsr_q 0x01; no done pulse.
- start held high across done -> second run begins with no gap; second ones_count equals an isolated run with the same inputs; start toggled during RUN is ignored.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-number generators.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_OR   = 2'd0;
    localparam logic [1:0] MODE_AND  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    // x^8+x^5+x^3+x^2+1 (0x12D), maximal length for a right-shifting Fibonacci LFSR
    localparam logic [7:0] DEF_TAPS     = 8'b0010_1101;
    localparam logic [7:0] DEF_INV_MASK = 8'b1101_0100;

endpackage

// File: rtl/sc_lfsr.sv
// Right-shifting Fibonacci LFSR with seed load and zero-seed lock-up guard.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    assign w_fb    = ^(r_state & TAPS);
    assign o_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WIDTH'(1);
        end else if (i_load) begin
            // an all-zero state would never leave zero
            r_state <= (i_seed == '0) ? WIDTH'(1) : i_seed;
        end else if (i_en) begin
            r_state <= {w_fb, r_state[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sc_sng_stream.sv
// Stochastic bitstream generator: LFSR-driven comparator, delay-chain decorrelation,
// mode-selectable combiner and a per-run ones counter.
module sc_sng_stream
    import sc_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = DEF_TAPS,
    parameter logic [WIDTH-1:0] INV_MASK = DEF_INV_MASK,
    parameter int               DEPTH    = 4,
    parameter int               LEN      = 255,
    parameter int               CNT_W    = $clog2(LEN+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] prob,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             bit_out,
    output logic [CNT_W-1:0] ones_count,
    output logic [WIDTH-1:0] lfsr_q
);

    state_t           r_state, w_state_nxt;
    logic             w_accept;
    logic             w_run;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_ones;
    logic [WIDTH-1:0] r_prob;
    logic [1:0]       r_mode;
    logic [DEPTH-2:0] r_dly;
    logic             r_bit;
    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_cmp;
    logic             w_x0;
    logic [DEPTH-1:0] w_x;
    logic             w_c;

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_seed  (seed),
        .i_en    (w_run),
        .o_state (w_lfsr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cyc == CNT_W'(LEN-1)) w_state_nxt = DONE;
            end
            DONE: begin
                // start during DONE chains straight into the next run
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_run = (r_state == RUN);

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) w_rev[i] = w_lfsr[WIDTH-1-i];
    end

    assign w_cmp = w_rev ^ INV_MASK;
    assign w_x0  = (w_cmp < r_prob);
    // w_x[i] is x0 delayed by i cycles
    assign w_x   = {r_dly, w_x0};

    always_comb begin
        w_c = 1'b0;
        case (r_mode)
            MODE_OR:   w_c = |w_x;
            MODE_AND:  w_c = &w_x;
            MODE_XOR:  w_c = ^w_x;
            MODE_PASS: w_c = w_x0;
            default:   w_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_ones  <= '0;
            r_prob  <= '0;
            r_mode  <= MODE_OR;
            r_dly   <= '0;
            r_bit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_run & w_c;
            if (w_accept) begin
                r_prob <= prob;
                r_mode <= mode;
                r_dly  <= '0;
                r_ones <= '0;
                r_cyc  <= '0;
            end else if (w_run) begin
                r_dly  <= w_x[DEPTH-2:0];
                r_ones <= r_ones + CNT_W'(w_c);
                r_cyc  <= r_cyc + 1'b1;
            end
        end
    end

    assign busy       = w_run;
    assign done       = (r_state == DONE);
    assign bit_out    = r_bit;
    assign ones_count = r_ones;
    assign lfsr_q     = w_lfsr;

endmodule

// File: tb/tb_sc_sng_stream.sv
// Directed bench for sc_sng_stream with default parameters and a bit-level reference model.
module tb_sc_sng_stream;
    import sc_pkg::*;

    localparam int LEN = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [7:0] prob;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       bit_out;
    logic [7:0] ones_count;
    logic [7:0] lfsr_q;

    int n_tests = 0;
    int n_fail  = 0;
    bit mbits[LEN];
    int m_cnt;

    always #5 clk = ~clk;

    sc_sng_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .prob       (prob),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .bit_out    (bit_out),
        .ones_count (ones_count),
        .lfsr_q     (lfsr_q)
    );

    // Reference: explicit x^8+x^5+x^3+x^2+1 recurrence and bit-reversed comparator.
    task automatic model_run(input logic [7:0] s, input logic [7:0] p, input logic [1:0] md);
        logic [7:0] l, rev, cmp;
        bit x0, x1, x2, x3, c;
        l = (s == 8'h00) ? 8'h01 : s;
        x1 = 0; x2 = 0; x3 = 0;
        m_cnt = 0;
        for (int k = 0; k < LEN; k++) begin
            for (int b = 0; b < 8; b++) rev[b] = l[7-b];
            cmp = rev ^ 8'hD4;
            x0  = (cmp < p);
            case (md)
                2'd0:    c = x0 | x1 | x2 | x3;
                2'd1:    c = x0 & x1 & x2 & x3;
                2'd2:    c = x0 ^ x1 ^ x2 ^ x3;
                default: c = x0;
            endcase
            mbits[k] = c;
            m_cnt += int'(c);
            x3 = x2; x2 = x1; x1 = x0;
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[7:1]};
        end
    endtask

    task automatic apply_start(input logic [7:0] s, input logic [7:0] p, input logic [1:0] md);
        @(negedge clk);
        start = 1'b1; seed = s; prob = p; mode = md;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one run and gathers observations; callers do the comparisons.
    task automatic run_collect(input logic [7:0] s, input logic [7:0] p, input logic [1:0] md,
                               output int lat, output int bad_busy, output int bad_bits,
                               output int cnt, output logic busy_done);
        int   n;
        logic exp_b;
        model_run(s, p, md);
        apply_start(s, p, md);
        n = 1; bad_busy = 0; bad_bits = 0;
        while (!done && n < 600) begin
            if (busy !== 1'b1) bad_busy++;
            exp_b = (n >= 2 && n - 2 < LEN) ? mbits[n-2] : 1'b0;
            if (bit_out !== exp_b) bad_bits++;
            @(negedge clk);
            n++;
        end
        exp_b = (n >= 2 && n - 2 < LEN) ? mbits[n-2] : 1'b0;
        if (bit_out !== exp_b) bad_bits++;
        lat = n; cnt = int'(ones_count); busy_done = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; seed = '0; prob = '0; mode = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (bit_out !== 1'b0) begin n_fail++; $display("FAIL reset_bit: got %b expected 0", bit_out); end
        n_tests++; if (ones_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", ones_count); end
        n_tests++; if (lfsr_q !== 8'h01) begin n_fail++; $display("FAIL reset_lfsr: got %h expected 01", lfsr_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_lfsr_period;
        logic [7:0] smp[$];
        bit         seen[256];
        int         n, distinct;
        apply_start(8'h01, 8'h80, MODE_OR);
        n = 1;
        while (!done && n < 600) begin
            if (busy) smp.push_back(lfsr_q);
            @(negedge clk);
            n++;
        end
        distinct = 0;
        foreach (smp[i]) if (smp[i] != 8'h00 && !seen[smp[i]]) begin seen[smp[i]] = 1; distinct++; end
        n_tests++; if (smp.size() !== 255) begin n_fail++; $display("FAIL lfsr_samples: got %0d expected 255", smp.size()); end
        n_tests++; if (distinct !== 255) begin n_fail++; $display("FAIL lfsr_distinct: got %0d expected 255", distinct); end
        n_tests++; if (lfsr_q !== 8'h01) begin n_fail++; $display("FAIL lfsr_wrap: got %h expected 01", lfsr_q); end
        if (smp.size() >= 5) begin
            n_tests++;
            if (smp[1] !== 8'h80 || smp[2] !== 8'h40 || smp[3] !== 8'h20 || smp[4] !== 8'h90) begin
                n_fail++;
                $display("FAIL lfsr_first: got %h %h %h %h expected 80 40 20 90", smp[1], smp[2], smp[3], smp[4]);
            end
        end
    endtask

    task automatic test_prob_zero;
        int lat, bb, bbits, cnt;
        logic bd;
        run_collect(8'h3C, 8'h00, MODE_OR, lat, bb, bbits, cnt, bd);
        n_tests++; if (lat !== 256) begin n_fail++; $display("FAIL p0_latency: got %0d expected 256", lat); end
        n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL p0_busy: got %0d low cycles expected 0", bb); end
        n_tests++; if (bd !== 1'b0) begin n_fail++; $display("FAIL p0_busy_at_done: got %b expected 0", bd); end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL p0_count: got %0d expected 0", cnt); end
        n_tests++; if (bbits !== 0) begin n_fail++; $display("FAIL p0_bits: got %0d bad bits expected 0", bbits); end
    endtask

    task automatic test_prob_full;
        int lat, bb, bbits, cnt;
        logic bd;
        run_collect(8'h5A, 8'hFF, MODE_PASS, lat, bb, bbits, cnt, bd);
        n_tests++; if (cnt !== 254) begin n_fail++; $display("FAIL pF_pass_count: got %0d expected 254", cnt); end
        n_tests++; if (bbits !== 0) begin n_fail++; $display("FAIL pF_pass_bits: got %0d bad bits expected 0", bbits); end
        run_collect(8'h5A, 8'hFF, MODE_OR, lat, bb, bbits, cnt, bd);
        n_tests++; if (cnt !== m_cnt || cnt < 254) begin n_fail++; $display("FAIL pF_or_count: got %0d expected %0d", cnt, m_cnt); end
        n_tests++; if (bbits !== 0) begin n_fail++; $display("FAIL pF_or_bits: got %0d bad bits expected 0", bbits); end
        run_collect(8'h5A, 8'hFF, MODE_AND, lat, bb, bbits, cnt, bd);
        n_tests++; if (cnt !== m_cnt || cnt < 248 || cnt > 252) begin n_fail++; $display("FAIL pF_and_count: got %0d expected %0d", cnt, m_cnt); end
        n_tests++; if (bbits !== 0) begin n_fail++; $display("FAIL pF_and_bits: got %0d bad bits expected 0", bbits); end
    endtask

    task automatic test_seed_zero;
        int lat, bb, bbits, cnt0, cnt1;
        logic bd;
        run_collect(8'h00, 8'h80, MODE_XOR, lat, bb, bbits, cnt0, bd);
        n_tests++; if (bbits !== 0) begin n_fail++; $display("FAIL s0_bits: got %0d bad bits expected 0", bbits); end
        run_collect(8'h01, 8'h80, MODE_XOR, lat, bb, bbits, cnt1, bd);
        n_tests++; if (cnt0 !== cnt1) begin n_fail++; $display("FAIL s0_vs_s1: got %0d expected %0d", cnt0, cnt1); end
        n_tests++; if (cnt1 !== m_cnt) begin n_fail++; $display("FAIL s1_count: got %0d expected %0d", cnt1, m_cnt); end
    endtask

    task automatic test_reset_midrun;
        int done_seen;
        apply_start(8'h5A, 8'h80, MODE_OR);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_tests++; if (ones_count !== 8'd0) begin n_fail++; $display("FAIL abort_count: got %0d expected 0", ones_count); end
        n_tests++; if (bit_out !== 1'b0) begin n_fail++; $display("FAIL abort_bit: got %b expected 0", bit_out); end
        n_tests++; if (lfsr_q !== 8'h01) begin n_fail++; $display("FAIL abort_lfsr: got %h expected 01", lfsr_q); end
        rst_n = 1'b1;
        done_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_tests++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
    endtask

    task automatic test_back_to_back;
        int lat, bb, bbits, iso_cnt, a_cnt, n;
        logic bd;
        run_collect(8'h33, 8'h60, MODE_AND, lat, bb, bbits, iso_cnt, bd);
        model_run(8'hA7, 8'h90, MODE_XOR);
        a_cnt = m_cnt;
        apply_start(8'hA7, 8'h90, MODE_XOR);
        n = 1;
        while (!done && n < 600) begin
            if (n == 50) begin start = 1'b1; seed = 8'h11; prob = 8'hFF; mode = MODE_OR; end
            if (n == 51) start = 1'b0;
            if (n == 250) begin start = 1'b1; seed = 8'h33; prob = 8'h60; mode = MODE_AND; end
            @(negedge clk);
            n++;
        end
        n_tests++; if (n !== 256) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 256", n); end
        n_tests++; if (int'(ones_count) !== a_cnt) begin n_fail++; $display("FAIL b2b_first_count: got %0d expected %0d", ones_count, a_cnt); end
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        n = 1;
        while (!done && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_tests++; if (n !== 256) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 256", n); end
        n_tests++; if (int'(ones_count) !== iso_cnt) begin n_fail++; $display("FAIL b2b_second_count: got %0d expected %0d", ones_count, iso_cnt); end
    endtask

    initial begin
        test_reset();
        test_lfsr_period();
        test_prob_zero();
        test_prob_full();
        test_seed_zero();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
